// File: rtl/sdp_ram_be.sv
// rtl/sdp_ram_be.sv - simple dual-port RAM with byte enables, read-valid strobe,
// optional output register, write-first collision forwarding and post-reset clear sweep
module sdp_ram_be #(
  parameter int WIDTH          = 32,
  parameter int ENTRIES        = 256,
  parameter int BYTE_W         = 8,
  parameter int OUTPUT_REG     = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB            = WIDTH / BYTE_W,
  localparam int AW            = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     waddr,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              writeEnable,
  input  logic [NB-1:0]     byteEnable,
  input  logic [AW-1:0]     raddr,
  input  logic              readEnable,
  output logic [WIDTH-1:0]  readData,
  output logic              readValid,
  output logic              busy
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [AW:0]   LIMIT = (AW+1)'(ENTRIES);
  localparam logic [AW-1:0] LAST  = AW'(ENTRIES - 1);

  logic [WIDTH-1:0] mem_q [ENTRIES];

  state_t           state_q;
  logic [AW-1:0]    cnt_q;
  logic             busy_q;

  logic             run;
  logic             wr_ok;
  logic             rd_acc;
  logic             rd_in;
  logic [NB-1:0]    fwd_mask_d;

  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic [NB-1:0]    mem_wm;

  logic [WIDTH-1:0] rd_mem_q;
  logic             v1_q;
  logic             oor_q;
  logic             have_q;
  logic [NB-1:0]    fwd_mask_q;
  logic [WIDTH-1:0] fwd_data_q;
  logic [WIDTH-1:0] merged;

  assign run        = (state_q == S_RUN);
  assign wr_ok      = run && writeEnable && ({1'b0, waddr} < LIMIT);
  assign rd_acc     = run && readEnable;
  assign rd_in      = rd_acc && ({1'b0, raddr} < LIMIT);
  assign fwd_mask_d = byteEnable & {NB{wr_ok && (waddr == raddr)}};
  assign busy       = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt_q   <= '0;
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == LAST) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + AW'(1);
          end
        end
        default: begin
          state_q <= S_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The sweep and the user write share one write port so the array stays single-ported per side.
  always_comb begin
    mem_wa = waddr;
    mem_wd = writeData;
    mem_wm = wr_ok ? byteEnable : '0;
    if (state_q == S_CLEAR) begin
      mem_wa = cnt_q;
      mem_wd = '0;
      mem_wm = '1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_wm[i]) begin
        mem_q[mem_wa][i*BYTE_W +: BYTE_W] <= mem_wd[i*BYTE_W +: BYTE_W];
      end
    end
    if (rd_in) begin
      rd_mem_q <= mem_q[raddr];
    end
  end

  // Collision lanes are captured beside the array and merged after it, keeping the array reset-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      oor_q      <= 1'b0;
      have_q     <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) begin
        oor_q      <= !rd_in;
        have_q     <= 1'b1;
        fwd_mask_q <= fwd_mask_d;
        fwd_data_q <= writeData;
      end
    end
  end

  always_comb begin
    merged = '0;
    for (int i = 0; i < NB; i++) begin
      merged[i*BYTE_W +: BYTE_W] = fwd_mask_q[i] ? fwd_data_q[i*BYTE_W +: BYTE_W]
                                                 : rd_mem_q[i*BYTE_W +: BYTE_W];
    end
    if (oor_q || !have_q) begin
      merged = '0;
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= v1_q;
        if (v1_q) begin
          rdata_q <= merged;
        end
      end
    end

    assign readData  = rdata_q;
    assign readValid = rvalid_q;
  end else begin : g_noreg
    assign readData  = merged;
    assign readValid = v1_q;
  end

endmodule
